// File: rtl/prg_monitor_pkg.sv
// Shared constants and state encoding for the monitor-link programming master.
package prg_monitor_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    RWAIT,
    RESP
  } state_t;

endpackage

// File: rtl/shift_pack32.sv
// Packs four big-endian bytes into a 32-bit word; 'last' flags the byte that
// completes the word. 'clr' restarts the byte count but keeps the word value.
module shift_pack32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last
);

  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      word <= 32'h0;
      cnt  <= 2'd0;
    end else begin
      if (clr)
        cnt <= 2'd0;
      else if (load)
        cnt <= cnt + 2'd1;
      if (load)
        word <= {word[23:0], din};
    end
  end

  assign last = load && (cnt == 2'd3);

endmodule

// File: rtl/prg_bus_master.sv
// Byte-stream command master for the data-memory programming port.
// Optional inter-byte timeout is enabled by defining PRG_TIMEOUT_EN.
module prg_bus_master
  import prg_monitor_pkg::*;
#(
  parameter int RD_LATENCY     = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prg_we,
  output logic [31:0] prg_addr,
  output logic [31:0] prg_wd,
  input  logic [31:0] prg_rd,
  output logic        busy
);

  if (RD_LATENCY < 1 || RD_LATENCY > 7 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("prg_bus_master: parameter out of range");
  end

  state_t      state;
  logic        is_read;
  logic [2:0]  lat_cnt;
  logic [23:0] resp_rest;
  logic [1:0]  resp_left;
  logic        rx_fire;
  logic        tx_fire;
  logic        addr_last;
  logic        data_last;
  logic        timeout_hit;

  assign rx_ready = (state == IDLE) || (state == ADDR) || (state == DATA);
  assign busy     = (state != IDLE);
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;

  shift_pack32 u_addr (
    .clk   (clk),
    .reset (reset),
    .clr   (state == IDLE),
    .load  (rx_fire && (state == ADDR)),
    .din   (rx_data),
    .word  (prg_addr),
    .last  (addr_last)
  );

  shift_pack32 u_data (
    .clk   (clk),
    .reset (reset),
    .clr   (state == IDLE),
    .load  (rx_fire && (state == DATA)),
    .din   (rx_data),
    .word  (prg_wd),
    .last  (data_last)
  );

`ifdef PRG_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 20) ? $clog2(TIMEOUT_CYCLES + 1) : 20;

  logic [TO_W-1:0] to_cnt;
  logic            in_field;

  assign in_field    = (state == ADDR) || (state == DATA);
  assign timeout_hit = in_field && !rx_fire && (to_cnt == TO_W'(TIMEOUT_CYCLES));

  // Gap counter restarts on every accepted byte and only runs mid-command.
  always_ff @(posedge clk) begin
    if (reset || rx_fire || !in_field)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      is_read   <= 1'b0;
      lat_cnt   <= 3'd0;
      resp_rest <= 24'h0;
      resp_left <= 2'd0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      prg_we    <= 1'b0;
    end else begin
      prg_we <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_fire) begin
            if (rx_data == OP_WRITE || rx_data == OP_READ) begin
              is_read <= (rx_data == OP_READ);
              state   <= ADDR;
            end else begin
              tx_data   <= NAK;
              tx_valid  <= 1'b1;
              resp_left <= 2'd0;
              state     <= RESP;
            end
          end
        end
        ADDR: begin
          lat_cnt <= 3'd0;
          if (addr_last) begin
            state <= is_read ? RWAIT : DATA;
          end else if (timeout_hit) begin
            tx_data   <= NAK;
            tx_valid  <= 1'b1;
            resp_left <= 2'd0;
            state     <= RESP;
          end
        end
        DATA: begin
          if (data_last) begin
            prg_we <= 1'b1;
            state  <= WRITE;
          end else if (timeout_hit) begin
            tx_data   <= NAK;
            tx_valid  <= 1'b1;
            resp_left <= 2'd0;
            state     <= RESP;
          end
        end
        WRITE: begin
          tx_data   <= ACK;
          tx_valid  <= 1'b1;
          resp_left <= 2'd0;
          state     <= RESP;
        end
        RWAIT: begin
          // Read data is valid in the final wait cycle of the RAM latency.
          if (lat_cnt == 3'(RD_LATENCY - 1)) begin
            tx_data   <= prg_rd[31:24];
            resp_rest <= prg_rd[23:0];
            tx_valid  <= 1'b1;
            resp_left <= 2'd3;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RESP: begin
          if (tx_fire) begin
            if (resp_left == 2'd0) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end else begin
              tx_data   <= resp_rest[23:16];
              resp_rest <= {resp_rest[15:0], 8'h00};
              resp_left <= resp_left - 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prg_bus_master.sv
// Self-checking bench for prg_bus_master with a behavioural memory and
// command-level reference model; timeout test runs when PRG_TIMEOUT_EN is set.
module tb_prg_bus_master;

  localparam int RD_LAT   = 2;
  localparam int TO_CYC   = 100;
  localparam int PIPE_IDX = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        prg_we;
  logic [31:0] prg_addr;
  logic [31:0] prg_wd;
  logic [31:0] prg_rd;
  logic        busy;

  always #5 clk = ~clk;

  prg_bus_master #(.RD_LATENCY(RD_LAT), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .prg_we   (prg_we),
    .prg_addr (prg_addr),
    .prg_wd   (prg_wd),
    .prg_rd   (prg_rd),
    .busy     (busy)
  );

  // Memory environment: registered-output RAM with configurable read latency.
  logic [31:0] mem [0:2047];
  logic [31:0] rd_pipe [0:6];

  initial for (int i = 0; i < 2048; i++) mem[i] = 32'h0;

  always @(posedge clk) begin
    if (prg_we) mem[prg_addr[12:2]] <= prg_wd;
    rd_pipe[0] <= mem[prg_addr[12:2]];
    for (int i = 1; i < 7; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign prg_rd = (RD_LAT == 1) ? mem[prg_addr[12:2]] : rd_pipe[PIPE_IDX];

  int          we_count = 0;
  logic [31:0] we_addr_last;
  logic [31:0] we_data_last;

  always @(posedge clk) begin
    if (prg_we) begin
      we_count     <= we_count + 1;
      we_addr_last <= prg_addr;
      we_data_last <= prg_wd;
    end
  end

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [int];
  logic [7:0]  cmd_q[$];
  logic [7:0]  exp_resp[$];
  logic [7:0]  got_q[$];
  bit          exp_we;
  logic [31:0] exp_wa;
  logic [31:0] exp_wd;

  typedef struct {
    logic [71:0] cmd;
    int          n_cmd;
    logic [31:0] exp_word;
    int          n_resp;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      tick();
      n++;
    end
    if (!rx_ready) checkOutput("rx_accept_timeout", 32'd0, 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic recvByte(output logic [7:0] b, input int max_stall);
    int n = 0;
    tx_ready = 1'b0;
    repeat ($urandom_range(0, max_stall)) tick();
    tx_ready = 1'b1;
    while (!tx_valid && n < 200) begin
      tick();
      n++;
    end
    if (!tx_valid) begin
      checkOutput("tx_wait_timeout", 32'd0, 32'd1);
      b = 8'h00;
    end else begin
      b = tx_data;
    end
    tick();
    tx_ready = 1'b0;
  endtask

  // Command-level reference: interprets the byte stream directly from the protocol rules.
  task automatic refModel();
    logic [31:0] a;
    logic [31:0] d;
    int          idx;
    exp_resp.delete();
    exp_we = 1'b0;
    if (cmd_q.size() == 9 && cmd_q[0] == 8'h57) begin
      a   = {cmd_q[1], cmd_q[2], cmd_q[3], cmd_q[4]};
      d   = {cmd_q[5], cmd_q[6], cmd_q[7], cmd_q[8]};
      idx = int'(a[12:2]);
      ref_mem[idx] = d;
      exp_we = 1'b1;
      exp_wa = a;
      exp_wd = d;
      exp_resp.push_back(8'h06);
    end else if (cmd_q.size() == 5 && cmd_q[0] == 8'h52) begin
      a   = {cmd_q[1], cmd_q[2], cmd_q[3], cmd_q[4]};
      idx = int'(a[12:2]);
      d   = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
      for (int k = 3; k >= 0; k--) exp_resp.push_back(d[8*k +: 8]);
    end else begin
      exp_resp.push_back(8'h15);
    end
  endtask

  task automatic applyStimulus(input string name, input int max_stall);
    int         we0;
    logic [7:0] b;
    we0 = we_count;
    refModel();
    got_q.delete();
    foreach (cmd_q[i]) sendByte(cmd_q[i]);
    for (int i = 0; i < exp_resp.size(); i++) begin
      recvByte(b, max_stall);
      got_q.push_back(b);
      checkOutput({name, "_resp"}, {24'h0, b}, {24'h0, exp_resp[i]});
    end
    tick();
    checkOutput({name, "_we_count"}, we_count - we0, {31'h0, exp_we});
    if (exp_we) begin
      checkOutput({name, "_we_addr"}, we_addr_last, exp_wa);
      checkOutput({name, "_we_data"}, we_data_last, exp_wd);
    end
    checkOutput({name, "_busy_after"}, {31'h0, busy}, 32'd0);
  endtask

  task automatic loadCmd(input logic [71:0] cmd, input int n);
    cmd_q.delete();
    for (int j = 0; j < n; j++) cmd_q.push_back(cmd[71 - 8*j -: 8]);
  endtask

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [7:0]  b;
    logic [7:0]  held;
    logic [31:0] word;
    logic [31:0] a;
    int          n;
    int          bad;
    int          we0;

    vecs[0] = '{72'h57_00000010_DEADBEEF, 9, 32'h06,        1};
    vecs[1] = '{72'h52_00000010_00000000, 5, 32'hDEADBEEF,  4};
    vecs[2] = '{72'h41_00000000_00000000, 1, 32'h15,        1};
    vecs[3] = '{72'h57_00000010_12345678, 9, 32'h06,        1};
    vecs[4] = '{72'h52_00000010_00000000, 5, 32'h12345678,  4};
    vecs[5] = '{72'h57_00000023_CAFEF00D, 9, 32'h06,        1};
    vecs[6] = '{72'h52_00000020_00000000, 5, 32'hCAFEF00D,  4};
    vecs[7] = '{72'hFF_00000000_00000000, 1, 32'h15,        1};

    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    checkOutput("reset_rx_ready", {31'h0, rx_ready}, 32'd1);
    checkOutput("reset_tx_valid", {31'h0, tx_valid}, 32'd0);
    checkOutput("reset_tx_data",  {24'h0, tx_data},  32'd0);
    checkOutput("reset_prg_we",   {31'h0, prg_we},   32'd0);
    checkOutput("reset_prg_addr", prg_addr,          32'd0);
    checkOutput("reset_prg_wd",   prg_wd,            32'd0);
    checkOutput("reset_busy",     {31'h0, busy},     32'd0);

    for (int v = 0; v < 8; v++) begin
      loadCmd(vecs[v].cmd, vecs[v].n_cmd);
      applyStimulus($sformatf("vec%0d", v), 2);
      if (vecs[v].n_resp == 1)
        word = {24'h0, got_q[0]};
      else
        word = {got_q[0], got_q[1], got_q[2], got_q[3]};
      checkOutput($sformatf("vec%0d_table", v), word, vecs[v].exp_word);
    end

    // Write latency: strobe right after the last data byte, ACK one cycle later.
    loadCmd(72'h57_00000044_A5A55A5A, 9);
    refModel();
    we0 = we_count;
    foreach (cmd_q[i]) sendByte(cmd_q[i]);
    checkOutput("wr_lat_we",   {31'h0, prg_we}, 32'd1);
    checkOutput("wr_lat_addr", prg_addr, 32'h00000044);
    checkOutput("wr_lat_data", prg_wd,   32'hA5A55A5A);
    checkOutput("wr_lat_txv0", {31'h0, tx_valid}, 32'd0);
    tick();
    checkOutput("wr_lat_we_drop", {31'h0, prg_we}, 32'd0);
    checkOutput("wr_lat_ack_v",   {31'h0, tx_valid}, 32'd1);
    checkOutput("wr_lat_ack_d",   {24'h0, tx_data}, 32'h06);
    recvByte(b, 0);
    checkOutput("wr_lat_ack_rx", {24'h0, b}, 32'h06);
    tick();
    checkOutput("wr_lat_one_pulse", we_count - we0, 32'd1);

    // Read latency plus 20-cycle backpressure between every response byte.
    loadCmd(72'h52_00000010_00000000, 5);
    refModel();
    foreach (cmd_q[i]) sendByte(cmd_q[i]);
    n = 0;
    while (!tx_valid && n < 50) begin
      tick();
      n++;
    end
    checkOutput("rd_latency", n + 1, RD_LAT + 1);
    for (int k = 0; k < 4; k++) begin
      bad = 0;
      n   = 0;
      while (!tx_valid && n < 50) begin
        tick();
        n++;
      end
      held = tx_data;
      repeat (20) begin
        if (!tx_valid || tx_data !== held || rx_ready || !busy) bad++;
        tick();
      end
      checkOutput($sformatf("bp_stable%0d", k), bad, 32'd0);
      tx_ready = 1'b1;
      b = tx_data;
      tick();
      tx_ready = 1'b0;
      checkOutput($sformatf("bp_byte%0d", k), {24'h0, b}, {24'h0, exp_resp[k]});
    end
    tick();
    checkOutput("bp_no_extra", {31'h0, tx_valid}, 32'd0);
    checkOutput("bp_idle",     {31'h0, busy},     32'd0);

    // Bad opcode then a write that must still succeed.
    loadCmd(72'h41_00000000_00000000, 1);
    applyStimulus("nak_then", 0);
    loadCmd(72'h57_00000030_0BADF00D, 9);
    applyStimulus("after_nak_wr", 1);

    // Reset mid-command drops the partial write.
    we0 = we_count;
    sendByte(8'h57);
    sendByte(8'h00);
    sendByte(8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_busy", {31'h0, busy}, 32'd0);
    loadCmd(72'h52_00000010_00000000, 5);
    applyStimulus("midrst_rd", 1);
    checkOutput("midrst_no_write", we_count - we0, 32'd0);

    // Inter-byte gap behaviour.
    we0 = we_count;
    sendByte(8'h52);
    sendByte(8'h00);
`ifdef PRG_TIMEOUT_EN
    repeat (99) tick();
    checkOutput("to_early", {31'h0, tx_valid}, 32'd0);
    repeat (2) tick();
    checkOutput("to_nak_v", {31'h0, tx_valid}, 32'd1);
    checkOutput("to_nak_d", {24'h0, tx_data}, 32'h15);
    recvByte(b, 0);
    tick();
    checkOutput("to_idle",  {31'h0, busy}, 32'd0);
    checkOutput("to_no_we", we_count - we0, 32'd0);
`else
    repeat (150) tick();
    checkOutput("gap_no_tx",  {31'h0, tx_valid}, 32'd0);
    checkOutput("gap_busy",   {31'h0, busy},     32'd1);
    checkOutput("gap_rx_rdy", {31'h0, rx_ready}, 32'd1);
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h10);
    cmd_q.delete();
    cmd_q.push_back(8'h52);
    cmd_q.push_back(8'h00);
    cmd_q.push_back(8'h00);
    cmd_q.push_back(8'h00);
    cmd_q.push_back(8'h10);
    refModel();
    for (int k = 0; k < 4; k++) begin
      recvByte(b, 1);
      checkOutput($sformatf("gap_rd%0d", k), {24'h0, b}, {24'h0, exp_resp[k]});
    end
    tick();
    checkOutput("gap_no_we", we_count - we0, 32'd0);
`endif

    // Randomized command mix against the reference model.
    for (int r = 0; r < 40; r++) begin
      cmd_q.delete();
      a = $urandom;
      a[12:2] = 11'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: begin
          cmd_q.push_back(8'h57);
          for (int k = 3; k >= 0; k--) cmd_q.push_back(a[8*k +: 8]);
          word = $urandom;
          for (int k = 3; k >= 0; k--) cmd_q.push_back(word[8*k +: 8]);
        end
        1: begin
          cmd_q.push_back(8'h52);
          for (int k = 3; k >= 0; k--) cmd_q.push_back(a[8*k +: 8]);
        end
        default: begin
          b = 8'($urandom);
          while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
          cmd_q.push_back(b);
        end
      endcase
      applyStimulus($sformatf("rnd%0d", r), 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
